column_streamer: RTL and testbench

Parametrised column-streaming controller for the rotating display. It walks the scan index over `SCAN_RATE` positions, presents that index to the per-mode column generators, and waits a programmable settle time so combinational generators can resolve. It then registers the selected mode's columns for `NUM_CHANNELS` panel halves and hands them to the HUB75 driver with a one-cycle valid pulse. It adds the following:
- blanking of masked columns;
- sweep restart on a `dtheta` change;
- a frame-done pulse;
- overrun detection.

---
 rtl/column_streamer_pkg.sv | 22 ++
 rtl/column_streamer_if.sv | 27 ++
 rtl/column_streamer_mux.sv | 27 ++
 rtl/column_streamer.sv | 155 +++++++++++++++
 tb/tb_column_streamer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/column_streamer_pkg.sv
// Shared types and constants for the rotating-display column path.
// Column-path modules import this package.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2
  } state_t;

  localparam int RGB_RES_DEF  = 9;
  localparam int NUM_ROWS_DEF = 64;

  typedef logic [RGB_RES_DEF-1:0] pixel_t;
  typedef pixel_t [NUM_ROWS_DEF-1:0] column_t;

  localparam logic [1:0] MODE_CYLINDER = 2'd0;
  localparam logic [1:0] MODE_SPHERE   = 2'd1;
  localparam logic [1:0] MODE_CUBE     = 2'd2;
  localparam logic [1:0] MODE_BOIDS    = 2'd3;

endpackage

// File: rtl/column_streamer_if.sv
// Handshake and column bus between the column streamer and the HUB75 driver.
// The driver holds the master modport and the streamer holds the slave modport.
interface column_streamer_if #(
  parameter int NUM_ROWS     = 64,
  parameter int RGB_RES      = 9,
  parameter int NUM_CHANNELS = 2,
  parameter int COL_W        = 6
);

  logic                                             hub75_ready_in;
  logic [NUM_CHANNELS-1:0][NUM_ROWS-1:0][RGB_RES-1:0] columns_out;
  logic [NUM_CHANNELS-1:0][COL_W-1:0]                 col_num_out;
  logic                                             data_valid_out;
  logic                                             frame_done_out;
  logic                                             overrun_out;

  modport master (
    output hub75_ready_in,
    input  columns_out, col_num_out, data_valid_out, frame_done_out, overrun_out
  );

  modport slave (
    input  hub75_ready_in,
    output columns_out, col_num_out, data_valid_out, frame_done_out, overrun_out
  );

endinterface

// File: rtl/column_streamer_mux.sv
// Selects the latched mode's generator columns and blanks them when the
// current scan index is masked off or the mode has no generator.
module column_mux #(
  parameter int NUM_ROWS     = 64,
  parameter int RGB_RES      = 9,
  parameter int NUM_CHANNELS = 2,
  parameter int NUM_MODES    = 4
) (
  input  logic [NUM_MODES-1:0][NUM_CHANNELS-1:0][NUM_ROWS-1:0][RGB_RES-1:0] src_columns_in,
  input  logic [$clog2(NUM_MODES)-1:0]                                      mode_in,
  input  logic                                                              lit_in,
  output logic [NUM_CHANNELS-1:0][NUM_ROWS-1:0][RGB_RES-1:0]                columns_out
);

  localparam int MODE_W = $clog2(NUM_MODES);

  // Modes without a generator fall through every comparison and stay blank.
  always_comb begin
    columns_out = '0;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (lit_in && (mode_in == MODE_W'(m))) begin
        columns_out = src_columns_in[m];
      end
    end
  end

endmodule

// File: rtl/column_streamer.sv
// Walks the scan index, waits for generators to settle, then registers one
// transfer of masked columns for the HUB75 driver per ready edge.
module column_streamer
  import display_pkg::*;
#(
  parameter int ROTATIONAL_RES = 1024,
  parameter int NUM_ROWS       = 64,
  parameter int SCAN_RATE      = 32,
  parameter int RGB_RES        = 9,
  parameter int NUM_CHANNELS   = 2,
  parameter int NUM_MODES      = 4,
  parameter int SETTLE_CYCLES  = 1
) (
  input  logic                                                              clk_in,
  input  logic                                                              rst_in,
  input  logic [$clog2(NUM_MODES)-1:0]                                      mode_in,
  input  logic [$clog2(ROTATIONAL_RES)-1:0]                                 dtheta_in,
  input  logic [SCAN_RATE-1:0]                                              col_mask_in,
  output logic [$clog2(SCAN_RATE)-1:0]                                      src_index_out,
  input  logic [NUM_MODES-1:0][NUM_CHANNELS-1:0][NUM_ROWS-1:0][RGB_RES-1:0] src_columns_in,
  column_streamer_if.slave                                                  hub
);

  localparam int IDX_W  = $clog2(SCAN_RATE);
  localparam int COL_W  = $clog2(SCAN_RATE * NUM_CHANNELS);
  localparam int MODE_W = $clog2(NUM_MODES);
  localparam int TH_W   = $clog2(ROTATIONAL_RES);
  localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(SCAN_RATE - 1);

  typedef logic [NUM_CHANNELS-1:0][NUM_ROWS-1:0][RGB_RES-1:0] cols_t;
  typedef logic [NUM_CHANNELS-1:0][COL_W-1:0]                 col_nums_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [TH_W-1:0]   dtheta_q;
  logic              ready_q;
  logic              restart_pend_q, restart_pend_d;
  logic              req_pend_q, req_pend_d;
  cols_t             columns_q, columns_d, mux_columns;
  col_nums_t         col_num_q, col_num_d;
  logic              valid_q, valid_d;
  logic              frame_done_q, frame_done_d;
  logic              overrun_q, overrun_d;
  logic              request;
  logic              theta_moved;

  assign request     = hub.hub75_ready_in & ~ready_q;
  assign theta_moved = (dtheta_in != dtheta_q);

  column_mux #(
    .NUM_ROWS     (NUM_ROWS),
    .RGB_RES      (RGB_RES),
    .NUM_CHANNELS (NUM_CHANNELS),
    .NUM_MODES    (NUM_MODES)
  ) u_mux (
    .src_columns_in (src_columns_in),
    .mode_in        (mode_q),
    .lit_in         (col_mask_in[index_q]),
    .columns_out    (mux_columns)
  );

  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    cnt_d          = cnt_q;
    mode_d         = mode_q;
    restart_pend_d = restart_pend_q | theta_moved;
    req_pend_d     = req_pend_q;
    columns_d      = columns_q;
    col_num_d      = col_num_q;
    valid_d        = 1'b0;
    frame_done_d   = 1'b0;
    overrun_d      = overrun_q | (request & (state_q != IDLE));

    unique case (state_q)
      IDLE: begin
        // A pending restart wins; a coincident request is parked for next cycle.
        if (restart_pend_q) begin
          index_d        = '0;
          restart_pend_d = theta_moved;
          req_pend_d     = req_pend_q | request;
        end else if (request || req_pend_q) begin
          state_d    = SETTLE;
          cnt_d      = '0;
          mode_d     = mode_in;
          req_pend_d = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d      = EMIT;
          columns_d    = mux_columns;
          valid_d      = 1'b1;
          frame_done_d = (index_q == IDX_LAST);
          for (int c = 0; c < NUM_CHANNELS; c++) begin
            col_num_d[c] = COL_W'(index_q) + COL_W'(c * SCAN_RATE);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EMIT: begin
        state_d = IDLE;
        if (!restart_pend_q) begin
          index_d = index_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= IDLE;
      index_q        <= '0;
      cnt_q          <= '0;
      mode_q         <= '0;
      dtheta_q       <= '0;
      ready_q        <= 1'b0;
      restart_pend_q <= 1'b0;
      req_pend_q     <= 1'b0;
      columns_q      <= '0;
      col_num_q      <= '0;
      valid_q        <= 1'b0;
      frame_done_q   <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      cnt_q          <= cnt_d;
      mode_q         <= mode_d;
      dtheta_q       <= dtheta_in;
      ready_q        <= hub.hub75_ready_in;
      restart_pend_q <= restart_pend_d;
      req_pend_q     <= req_pend_d;
      columns_q      <= columns_d;
      col_num_q      <= col_num_d;
      valid_q        <= valid_d;
      frame_done_q   <= frame_done_d;
      overrun_q      <= overrun_d;
    end
  end

  assign src_index_out      = index_q;
  assign hub.columns_out    = columns_q;
  assign hub.col_num_out    = col_num_q;
  assign hub.data_valid_out = valid_q;
  assign hub.frame_done_out = frame_done_q;
  assign hub.overrun_out    = overrun_q;

endmodule

// File: tb/tb_column_streamer.sv
// Directed bench for column_streamer: a default-sized instance and a
// 4-channel, 3-mode, 3-cycle-settle instance driven from one clock.
module tb_column_streamer;
  import display_pkg::*;

  localparam int ROWS    = 4;
  localparam int RGB     = 9;
  localparam int SR      = 32;
  localparam int CH_A    = 2;
  localparam int MODES_A = 4;
  localparam int SET_A   = 1;
  localparam int COLW_A  = 6;
  localparam int CH_B    = 4;
  localparam int MODES_B = 3;
  localparam int SET_B   = 3;
  localparam int COLW_B  = 7;

  typedef logic [CH_A-1:0][ROWS-1:0][RGB-1:0] cols_a_t;
  typedef logic [CH_B-1:0][ROWS-1:0][RGB-1:0] cols_b_t;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] mask;
    int          exp_idx;
    bit          exp_lit;
    int          exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [1:0]  mode_a, mode_b;
  logic [9:0]  dtheta_a, dtheta_b;
  logic [31:0] mask_a, mask_b;
  logic [4:0]  idx_a, idx_b;
  logic [MODES_A-1:0][CH_A-1:0][ROWS-1:0][RGB-1:0] src_a;
  logic [MODES_B-1:0][CH_B-1:0][ROWS-1:0][RGB-1:0] src_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  column_streamer_if #(.NUM_ROWS(ROWS), .RGB_RES(RGB), .NUM_CHANNELS(CH_A), .COL_W(COLW_A)) bus_a ();
  column_streamer_if #(.NUM_ROWS(ROWS), .RGB_RES(RGB), .NUM_CHANNELS(CH_B), .COL_W(COLW_B)) bus_b ();

  column_streamer #(
    .ROTATIONAL_RES(1024), .NUM_ROWS(ROWS), .SCAN_RATE(SR), .RGB_RES(RGB),
    .NUM_CHANNELS(CH_A), .NUM_MODES(MODES_A), .SETTLE_CYCLES(SET_A)
  ) dut_a (
    .clk_in(clk), .rst_in(rst_a), .mode_in(mode_a), .dtheta_in(dtheta_a),
    .col_mask_in(mask_a), .src_index_out(idx_a), .src_columns_in(src_a), .hub(bus_a)
  );

  column_streamer #(
    .ROTATIONAL_RES(1024), .NUM_ROWS(ROWS), .SCAN_RATE(SR), .RGB_RES(RGB),
    .NUM_CHANNELS(CH_B), .NUM_MODES(MODES_B), .SETTLE_CYCLES(SET_B)
  ) dut_b (
    .clk_in(clk), .rst_in(rst_b), .mode_in(mode_b), .dtheta_in(dtheta_b),
    .col_mask_in(mask_b), .src_index_out(idx_b), .src_columns_in(src_b), .hub(bus_b)
  );

  // Stand-in generators: each pixel is a distinct nonzero function of mode, channel, row and index.
  function automatic logic [RGB-1:0] gen_pix(int m, int c, int r, int idx);
    return RGB'(m * 67 + c * 29 + r * 13 + idx * 5 + 1);
  endfunction

  always_comb begin
    src_a = '0;
    src_b = '0;
    for (int m = 0; m < MODES_A; m++)
      for (int c = 0; c < CH_A; c++)
        for (int r = 0; r < ROWS; r++)
          src_a[m][c][r] = gen_pix(m, c, r, int'(idx_a));
    for (int m = 0; m < MODES_B; m++)
      for (int c = 0; c < CH_B; c++)
        for (int r = 0; r < ROWS; r++)
          src_b[m][c][r] = gen_pix(m, c, r, int'(idx_b));
  end

  function automatic cols_a_t exp_cols_a(int m, int idx, bit lit);
    cols_a_t v = '0;
    if (lit && m < MODES_A)
      for (int c = 0; c < CH_A; c++)
        for (int r = 0; r < ROWS; r++)
          v[c][r] = gen_pix(m, c, r, idx);
    return v;
  endfunction

  function automatic cols_b_t exp_cols_b(int m, int idx, bit lit);
    cols_b_t v = '0;
    if (lit && m < MODES_B)
      for (int c = 0; c < CH_B; c++)
        for (int r = 0; r < ROWS; r++)
          v[c][r] = gen_pix(m, c, r, idx);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One ready edge on instance A; mode_in is scrambled after the start edge to prove it was latched.
  task automatic apply_stimulus_a(input logic [1:0] mode, input logic [31:0] mask, input int exp_idx,
                                  input bit exp_lit, input int exp_lat, input bit flip_mode,
                                  input bit move_theta, input string tag);
    int lat;
    logic [CH_A-1:0][COLW_A-1:0] cn;
    mode_a = mode;
    mask_a = mask;
    bus_a.hub75_ready_in = 1'b1;
    tick();
    bus_a.hub75_ready_in = 1'b0;
    if (flip_mode) mode_a = ~mode;
    if (move_theta) dtheta_a = dtheta_a + 10'd7;
    lat = 1;
    while (!bus_a.data_valid_out && lat < 12) begin
      tick();
      lat++;
    end
    for (int c = 0; c < CH_A; c++) cn[c] = COLW_A'(exp_idx + c * SR);
    check_output({tag, " valid"}, 256'(bus_a.data_valid_out), 256'(1));
    check_output({tag, " latency"}, 256'(lat), 256'(exp_lat));
    check_output({tag, " columns"}, 256'(bus_a.columns_out), 256'(exp_cols_a(int'(mode), exp_idx, exp_lit)));
    check_output({tag, " col_num"}, 256'(bus_a.col_num_out), 256'(cn));
    check_output({tag, " frame_done"}, 256'(bus_a.frame_done_out), 256'(exp_idx == SR - 1));
    tick();
    check_output({tag, " valid drop"}, 256'(bus_a.data_valid_out), 256'(0));
  endtask

  task automatic apply_stimulus_b(input logic [1:0] mode, input int exp_idx, input string tag);
    int lat;
    logic [CH_B-1:0][COLW_B-1:0] cn;
    mode_b = mode;
    bus_b.hub75_ready_in = 1'b1;
    tick();
    bus_b.hub75_ready_in = 1'b0;
    mode_b = ~mode;
    lat = 1;
    while (!bus_b.data_valid_out && lat < 12) begin
      tick();
      lat++;
    end
    for (int c = 0; c < CH_B; c++) cn[c] = COLW_B'(exp_idx + c * SR);
    check_output({tag, " latency"}, 256'(lat), 256'(SET_B + 1));
    check_output({tag, " columns"}, 256'(bus_b.columns_out), 256'(exp_cols_b(int'(mode), exp_idx, 1'b1)));
    check_output({tag, " col_num"}, 256'(bus_b.col_num_out), 256'(cn));
    tick();
  endtask

  task automatic check_reset_a(input string tag);
    check_output({tag, " valid"}, 256'(bus_a.data_valid_out), 256'(0));
    check_output({tag, " frame_done"}, 256'(bus_a.frame_done_out), 256'(0));
    check_output({tag, " overrun"}, 256'(bus_a.overrun_out), 256'(0));
    check_output({tag, " columns"}, 256'(bus_a.columns_out), 256'(0));
    check_output({tag, " col_num"}, 256'(bus_a.col_num_out), 256'(0));
    check_output({tag, " index"}, 256'(idx_a), 256'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   pulses;

    vecs[0] = '{MODE_SPHERE,   32'hFFFF_FFFF, 0, 1'b1, 2};
    vecs[1] = '{MODE_CYLINDER, 32'h0000_0000, 1, 1'b0, 2};
    vecs[2] = '{MODE_CUBE,     32'hFFFF_FFFF, 2, 1'b1, 2};
    vecs[3] = '{MODE_BOIDS,    32'h0000_0008, 3, 1'b1, 2};
    vecs[4] = '{MODE_SPHERE,   32'hFFFF_FFEF, 4, 1'b0, 2};

    rst_a = 1'b1;
    rst_b = 1'b1;
    mode_a = '0;
    mode_b = '0;
    dtheta_a = '0;
    dtheta_b = '0;
    mask_a = '0;
    mask_b = 32'hFFFF_FFFF;
    bus_a.hub75_ready_in = 1'b0;
    bus_b.hub75_ready_in = 1'b0;
    tick();
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    check_reset_a("reset");
    check_output("reset b overrun", 256'(bus_b.overrun_out), 256'(0));
    tick();

    for (int i = 0; i < 5; i++)
      apply_stimulus_a(vecs[i].mode, vecs[i].mask, vecs[i].exp_idx, vecs[i].exp_lit,
                       vecs[i].exp_lat, 1'b1, 1'b0, $sformatf("vec%0d", i));

    // Full sweep from a fresh reset with alternating mask, wrapping back to index 0.
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    tick();
    for (int i = 0; i <= SR; i++)
      apply_stimulus_a(MODE_CUBE, 32'hAAAA_AAAA, i % SR, (i % 2) == 1, 2, 1'b1, 1'b0,
                       $sformatf("sweep%0d", i));

    for (int i = 1; i < 5; i++)
      apply_stimulus_a(MODE_SPHERE, 32'hFFFF_FFFF, i, 1'b1, 2, 1'b1, 1'b0, $sformatf("pre%0d", i));
    apply_stimulus_a(MODE_SPHERE, 32'hFFFF_FFFF, 5, 1'b1, 2, 1'b1, 1'b1, "theta idx5");
    apply_stimulus_a(MODE_CUBE, 32'hFFFF_FFFF, 0, 1'b1, 3, 1'b0, 1'b0, "theta restart");

    // Reset during SETTLE aborts the transfer.
    bus_a.hub75_ready_in = 1'b1;
    tick();
    bus_a.hub75_ready_in = 1'b0;
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check_reset_a("abort");
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus_a.data_valid_out) pulses++;
    end
    check_output("abort no valid", 256'(pulses), 256'(0));
    apply_stimulus_a(MODE_SPHERE, 32'hFFFF_FFFF, 0, 1'b1, 2, 1'b1, 1'b0, "after abort");

    apply_stimulus_b(2'd3, 0, "b mode3");
    apply_stimulus_b(MODE_CUBE, 1, "b mode2");

    // Second edge one cycle into SETTLE is dropped and flags overrun.
    mode_b = MODE_SPHERE;
    bus_b.hub75_ready_in = 1'b1;
    tick();
    bus_b.hub75_ready_in = 1'b0;
    tick();
    bus_b.hub75_ready_in = 1'b1;
    tick();
    bus_b.hub75_ready_in = 1'b0;
    check_output("overrun set", 256'(bus_b.overrun_out), 256'(1));
    tick();
    check_output("overrun valid", 256'(bus_b.data_valid_out), 256'(1));
    check_output("overrun columns", 256'(bus_b.columns_out), 256'(exp_cols_b(1, 2, 1'b1)));
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus_b.data_valid_out) pulses++;
    end
    check_output("overrun dropped edge", 256'(pulses), 256'(0));
    apply_stimulus_b(MODE_CYLINDER, 3, "b post overrun");
    check_output("overrun sticky", 256'(bus_b.overrun_out), 256'(1));
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    check_output("overrun cleared", 256'(bus_b.overrun_out), 256'(0));
    check_output("a no overrun", 256'(bus_a.overrun_out), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
